// File: rtl/bus_fabric.sv
// Single-master address-decoding fabric with read FSM and write fan-out.
// Define BUS_FABRIC_TIMEOUT_EN to enable the read timeout counter.
module bus_fabric #(
  parameter int W = 32,
  parameter int AW = 16,
  parameter int N = 4,
  parameter logic [N*AW-1:0] BASE = {16'h8000, 16'h5000, 16'h4000, 16'h0000},
  parameter logic [N*AW-1:0] MASK = {16'h8000, 16'hF000, 16'hF000, 16'hC000},
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  m_addr,
  input  logic           m_ren,
  input  logic           m_wen,
  input  logic [W-1:0]   m_wdata,
  input  logic [3:0]     m_wmask,
  output logic [W-1:0]   m_rdata,
  output logic           m_rd_valid,
  output logic           m_err,
  output logic [AW-1:0]  s_addr,
  output logic [W-1:0]   s_wdata,
  output logic [3:0]     s_wmask,
  output logic [N-1:0]   s_ren,
  output logic [N-1:0]   s_wen,
  input  logic [N*W-1:0] s_rdata,
  input  logic [N-1:0]   s_rd_valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, hit_idx;
  logic          hit_any;
  logic          wr_err_q, wr_err_d;
  logic          ack;
  logic          to_hit;

  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;
  assign s_wmask = m_wmask;
  assign ack     = s_rd_valid[sel_q];

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if ((m_addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
        hit_any = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

`ifdef BUS_FABRIC_TIMEOUT_EN
  logic [7:0] cnt_q;

  // A slave response landing on the timeout cycle takes precedence.
  assign to_hit = (state_q == WAIT) && (cnt_q == 8'(TIMEOUT)) && !ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (state_q != WAIT) begin
      cnt_q <= 8'd0;
    end else if (!ack) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    wr_err_d   = 1'b0;
    s_ren      = '0;
    s_wen      = '0;
    m_rd_valid = 1'b0;
    m_rdata    = '0;
    m_err      = wr_err_q;
    unique case (state_q)
      IDLE: begin
        if (m_ren) begin
          if (hit_any) begin
            s_ren[hit_idx] = 1'b1;
            sel_d          = hit_idx;
            state_d        = WAIT;
          end else begin
            state_d = ERR;
          end
        end else if (m_wen) begin
          if (hit_any) s_wen[hit_idx] = 1'b1;
          else wr_err_d = 1'b1;
        end
      end
      WAIT: begin
        m_err = 1'b0;
        if (to_hit) begin
          m_rd_valid = 1'b1;
          m_err      = 1'b1;
          state_d    = IDLE;
        end else begin
          s_ren[sel_q] = m_ren;
          m_rd_valid   = ack;
          m_rdata      = s_rdata[sel_q*W +: W];
          if (ack) state_d = IDLE;
        end
      end
      ERR: begin
        m_rd_valid = 1'b1;
        m_err      = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      s_ren      = '0;
      s_wen      = '0;
      m_rd_valid = 1'b0;
      m_rdata    = '0;
      m_err      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      wr_err_q <= wr_err_d;
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric with a response scoreboard.
// Timeout steps only run when BUS_FABRIC_TIMEOUT_EN is defined.
module tb_bus_fabric;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  m_addr;
  logic         m_ren, m_wen;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wmask;
  logic [31:0]  m_rdata;
  logic         m_rd_valid, m_err;
  logic [15:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wmask;
  logic [3:0]   s_ren, s_wen;
  logic [127:0] s_rdata;
  logic [3:0]   s_rd_valid;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];

  bus_fabric dut (
    .clk(clk), .rst(rst),
    .m_addr(m_addr), .m_ren(m_ren), .m_wen(m_wen),
    .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rdata(m_rdata), .m_rd_valid(m_rd_valid), .m_err(m_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_ren(s_ren), .s_wen(s_wen),
    .s_rdata(s_rdata), .s_rd_valid(s_rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic expect_resp(input string tag, input logic v);
    logic [32:0] e;
    check({tag, ".valid"}, 64'(m_rd_valid), 64'(v));
    if (m_rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check({tag, ".unexpected"}, 64'd1, 64'(exp_q.size()));
      end else begin
        e = exp_q.pop_front();
        check({tag, ".rdata"}, 64'(m_rdata), 64'(e[31:0]));
        check({tag, ".err"}, 64'(m_err), 64'(e[32]));
      end
    end
  endtask

  task automatic slave(input int idx, input logic [31:0] d);
    s_rd_valid = 4'b0;
    s_rd_valid[idx] = 1'b1;
    s_rdata[idx*32 +: 32] = d;
  endtask

  initial begin
    rst = 1'b1; m_addr = '0; m_ren = 0; m_wen = 0;
    m_wdata = '0; m_wmask = 4'hF; s_rdata = '0; s_rd_valid = '0;
    m_ren = 1'b1;
    settle();
    check("rst.s_ren", 64'(s_ren), 64'd0);
    check("rst.valid", 64'(m_rd_valid), 64'd0);
    tick(); tick();
    rst = 1'b0; m_ren = 1'b0;
    tick(); settle();
    check("idle.err", 64'(m_err), 64'd0);
    expect_resp("idle", 1'b0);

    // read 0x0010 from slave 0
    m_addr = 16'h0010; m_ren = 1'b1; settle();
    check("rd0.s_ren", 64'(s_ren), 64'h1);
    check("rd0.s_addr", 64'(s_addr), 64'h0010);
    exp_q.push_back({1'b0, 32'h12345678});
    tick(); slave(0, 32'h12345678); settle();
    expect_resp("rd0", 1'b1);
    tick(); m_ren = 0; s_rd_valid = '0; settle();
    expect_resp("rd0.after", 1'b0);
    check("rd0.rdata0", 64'(m_rdata), 64'd0);

    // mapped write 0x4004
    m_addr = 16'h4004; m_wen = 1'b1; m_wdata = 32'hA5; settle();
    check("wr.s_wen", 64'(s_wen), 64'h2);
    check("wr.s_wdata", 64'(s_wdata), 64'hA5);
    check("wr.err0", 64'(m_err), 64'd0);
    tick(); m_wen = 1'b0; settle();
    check("wr.s_wen1", 64'(s_wen), 64'd0);
    check("wr.err1", 64'(m_err), 64'd0);

    // unmapped read 0x6000
    m_addr = 16'h6000; m_ren = 1'b1; settle();
    check("urd.s_ren", 64'(s_ren), 64'd0);
    expect_resp("urd.c0", 1'b0);
    exp_q.push_back({1'b1, 32'h0});
    tick(); settle();
    expect_resp("urd.c1", 1'b1);
    tick(); m_ren = 1'b0; settle();
    expect_resp("urd.c2", 1'b0);

    // unmapped write
    m_wen = 1'b1; settle();
    check("uwr.s_wen", 64'(s_wen), 64'd0);
    check("uwr.err0", 64'(m_err), 64'd0);
    tick(); m_wen = 1'b0; settle();
    check("uwr.err1", 64'(m_err), 64'd1);
    check("uwr.valid", 64'(m_rd_valid), 64'd0);
    tick(); settle();
    check("uwr.err2", 64'(m_err), 64'd0);

    // read 0x8000, stray pulse from slave 2
    m_addr = 16'h8000; m_ren = 1'b1; settle();
    check("rd3.s_ren", 64'(s_ren), 64'h8);
    exp_q.push_back({1'b0, 32'hBEEF});
    tick(); slave(2, 32'hDEAD); settle();
    expect_resp("rd3.stray", 1'b0);
    tick(); s_rd_valid = '0; settle();
    expect_resp("rd3.w2", 1'b0);
    check("rd3.hold", 64'(s_ren), 64'h8);
    tick(); slave(3, 32'hBEEF); settle();
    expect_resp("rd3", 1'b1);
    tick(); m_ren = 1'b0; s_rd_valid = '0; settle();
    expect_resp("rd3.after", 1'b0);

    // read+write together, and write while waiting
    m_addr = 16'h4004; m_ren = 1'b1; m_wen = 1'b1; settle();
    check("rw.s_ren", 64'(s_ren), 64'h2);
    check("rw.s_wen", 64'(s_wen), 64'd0);
    exp_q.push_back({1'b0, 32'hCAFE0001});
    tick(); settle();
    check("rw.wait_wen", 64'(s_wen), 64'd0);
    expect_resp("rw.w1", 1'b0);
    tick(); slave(1, 32'hCAFE0001); settle();
    expect_resp("rw", 1'b1);
    tick(); m_ren = 0; m_wen = 0; s_rd_valid = '0; settle();

    // read 0x5004 from slave 2
    m_addr = 16'h5004; m_ren = 1'b1; settle();
    check("rd2.s_ren", 64'(s_ren), 64'h4);
    exp_q.push_back({1'b0, 32'h00C0FFEE});
    tick(); slave(2, 32'h00C0FFEE); settle();
    expect_resp("rd2", 1'b1);
    tick(); m_ren = 0; s_rd_valid = '0; settle();

    // reset in the second wait cycle
    m_addr = 16'h0010; m_ren = 1'b1;
    tick(); tick(); rst = 1'b1; settle();
    check("rstw.s_ren", 64'(s_ren), 64'd0);
    expect_resp("rstw.c0", 1'b0);
    tick(); rst = 1'b0; m_ren = 1'b0; settle();
    expect_resp("rstw.c1", 1'b0);
    tick(); slave(0, 32'h0BAD0BAD); settle();
    expect_resp("rstw.late", 1'b0);
    tick(); s_rd_valid = '0;
    m_addr = 16'h5000; m_ren = 1'b1; settle();
    check("rstw.idle", 64'(s_ren), 64'h4);
    exp_q.push_back({1'b0, 32'h55});
    tick(); slave(2, 32'h55); settle();
    expect_resp("rstw.new", 1'b1);
    tick(); m_ren = 0; s_rd_valid = '0; settle();

`ifdef BUS_FABRIC_TIMEOUT_EN
    // slave 3 never answers
    m_addr = 16'h8000; m_ren = 1'b1; settle();
    exp_q.push_back({1'b1, 32'h0});
    for (int i = 1; i <= 15; i++) begin
      tick(); settle();
      expect_resp("to.wait", 1'b0);
    end
    tick(); settle();
    expect_resp("to.fire", 1'b1);
    check("to.s_ren", 64'(s_ren), 64'd0);
    tick(); settle();
    expect_resp("to.after", 1'b0);
    check("to.next", 64'(s_ren), 64'h8);
    // response lands on the timeout cycle
    exp_q.push_back({1'b0, 32'h7777});
    for (int i = 1; i <= 15; i++) begin
      tick(); settle();
      expect_resp("tie.wait", 1'b0);
    end
    tick(); slave(3, 32'h7777); settle();
    expect_resp("tie", 1'b1);
    tick(); m_ren = 0; s_rd_valid = '0; settle();
`endif

    check("sb.empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 SHALL have parameter W, default 32: data width.
REQ-002 SHALL have parameter AW, default 16: address width.
REQ-003 SHALL have parameter N, default 4, range 1..8: slave port count.
REQ-004 SHALL have parameter BASE, default {16'h8000,16'h5000,16'h4000,16'h0000}: N packed AW-bit bases; slot i is bits [i*AW +: AW].
REQ-005 SHALL have parameter MASK, default {16'h8000,16'hF000,16'hF000,16'hC000}: N packed AW-bit decode masks.
REQ-006 SHALL have parameter TIMEOUT, default 15, range 1..255: read timeout in cycles.
REQ-007 SHALL have ports clk in 1 (sole clock, rising edge) and rst in 1 (synchronous, active-high reset).
REQ-008 SHALL have master ports m_addr in AW, m_ren in 1, m_wen in 1, m_wdata in W, m_wmask in 4.
REQ-009 SHALL have master ports m_rdata out W, m_rd_valid out 1, m_err out 1 (error qualifier for the response/pulse).
REQ-010 SHALL have slave ports s_addr out AW, s_wdata out W, s_wmask out 4 (shared); s_ren out N, s_wen out N (one bit per slave).
REQ-011 SHALL have slave ports s_rdata in N*W (slot i = [i*W +: W]) and s_rd_valid in N.

Function
REQ-012 SHALL decode hit[i] = ((m_addr & MASK_i) == BASE_i); on overlap, lowest index wins; no hit = unmapped.
REQ-013 SHALL drive s_addr, s_wdata, s_wmask combinationally from m_addr, m_wdata, m_wmask at all times.
REQ-014 SHALL implement FSM IDLE, WAIT, ERR; reset state IDLE.
REQ-015 In IDLE with m_ren and mapped slave k: assert s_ren[k] same cycle, register sel_q=k, go WAIT.
REQ-016 In WAIT: s_ren[sel_q]=m_ren; m_rd_valid=s_rd_valid[sel_q]; m_rdata=s_rdata[sel_q]; m_err=0.
REQ-017 In WAIT, the cycle m_rd_valid=1: go IDLE; a new read is accepted no earlier than the following cycle.
REQ-018 SHALL ignore s_rd_valid from any slave other than sel_q; such pulses never reach m_rd_valid.
REQ-019 In IDLE with m_ren and unmapped address: no s_ren; go ERR; next cycle m_rd_valid=1, m_err=1, m_rdata=0; then IDLE.
REQ-020 Master holds m_ren/m_addr stable until m_rd_valid; fabric behaviour on change mid-transaction is undefined.
REQ-021 In IDLE with m_wen: s_wen[k]=1 same cycle for mapped k; single cycle; FSM stays IDLE.
REQ-022 Unmapped write: no s_wen; m_err=1 for exactly one cycle, the cycle after m_wen; m_rd_valid stays 0.
REQ-023 m_ren and m_wen together in IDLE: treat as read; all s_wen suppressed.
REQ-024 m_wen outside IDLE: ignored, no s_wen.
REQ-025 Outside WAIT/ERR response cycles: m_rd_valid=0, m_rdata=0.

Reset
REQ-026 rst SHALL force FSM IDLE, sel_q=0, timeout counter=0, m_err=0 at the next rising clk.
REQ-027 During rst and the reset cycle: all s_ren=0, s_wen=0, m_rd_valid=0, m_rdata=0.
REQ-028 rst mid-WAIT SHALL abandon the transaction; a later s_rd_valid from that slave is ignored.

Configuration
REQ-029 Macro BUS_FABRIC_TIMEOUT_EN defined: 8-bit counter cleared on entering WAIT, incremented each WAIT cycle without s_rd_valid[sel_q].
REQ-030 With macro: when the counter reaches TIMEOUT, the following cycle gives m_rd_valid=1, m_err=1, m_rdata=0, s_ren deasserted, FSM to IDLE.
REQ-031 With macro: s_rd_valid[sel_q] arriving in the same cycle as the timeout response wins; normal data is returned with m_err=0.
REQ-032 Macro undefined: no counter logic; WAIT persists until s_rd_valid[sel_q].

Verification
REQ-033 Read 0x0010, slave 0 returns rd_valid one cycle later with 0x12345678 -> s_ren=4'b0001; m_rdata=0x12345678, m_rd_valid=1, m_err=0.
REQ-034 Write 0x4004 data 0xA5 -> s_wen=4'b0010 for exactly one cycle; no other s_wen; m_err stays 0.
REQ-035 Read 0x6000 (unmapped) -> no s_ren; m_rd_valid=1, m_err=1, m_rdata=0 on the second cycle.
REQ-036 Read 0x8000, slave 2 pulses rd_valid with 0xDEAD while waiting -> pulse ignored; only slave 3's response (e.g. 0xBEEF) is returned.
REQ-037 Macro on, TIMEOUT=15, slave 3 never responds -> m_rd_valid=1, m_err=1, m_rdata=0 exactly 16 cycles after ren; next read accepted.
REQ-038 rst asserted in the second WAIT cycle, slave responds two cycles later -> m_rd_valid stays 0; FSM IDLE.
